fsm_rx_tmr_param: RTL and testbench

Parametrised, configurable UART receive control FSM that sequences start, data, parity and stop bits from the baud-rate acquisition strobe. State, bit counter and config latch are triple-modular-redundant with bitwise majority voting and scrubbing every cycle. Sits between the Rx shift register / bit synchroniser and the Rx FIFO. Adds runtime data width, parity and stop-bit options, error flags, a byte output and TMR mismatch reporting.

---
 rtl/fsm_rx_pkg.sv | 44 ++++
 rtl/tmr_vote.sv | 16 +
 rtl/fsm_rx_tmr_param.sv | 225 ++++++++++++++++++++++
 tb/tb_fsm_rx_tmr_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fsm_rx_pkg.sv
// Shared definitions for the UART receive control FSM: one-hot state codes,
// parity-mode encodings, the latched frame configuration and a width clamp.
package fsm_rx_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  localparam int unsigned DATA_MIN = 5;

  typedef struct packed {
    logic [3:0] data_bits;
    logic [1:0] parity;
    logic       stop2;
  } cfg_t;

  localparam int unsigned CFG_W = $bits(cfg_t);

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
    if (req < 4'(DATA_MIN)) begin
      return 4'(DATA_MIN);
    end else if (req > max_bits) begin
      return max_bits;
    end
    return req;
  endfunction

  // Exactly one bit set; anything else is treated as a corrupted state.
  function automatic logic is_onehot5(input logic [4:0] s);
    return (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter with a flag raised when any copy disagrees
// with the voted result.
module tmr_vote #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o,
  output logic         mismatch_o
);

  assign y_o        = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign mismatch_o = |((a_i ^ y_o) | (b_i ^ y_o) | (c_i ^ y_o));

endmodule

// File: rtl/fsm_rx_tmr_param.sv
// UART receive control FSM with runtime frame format. State, bit counter and
// frame config are held in three voted copies that are rewritten every cycle.
module fsm_rx_tmr_param
  import fsm_rx_pkg::*;
#(
  parameter int unsigned DATA_MAX = 9,
  parameter int unsigned CNT_W    = 4,
  parameter bit          TMR_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Rx_Synch_i,
  input  logic                AcqSig_i,
  input  logic                RxBit_i,
  input  logic [3:0]          DataBits_i,
  input  logic [1:0]          ParityMode_i,
  input  logic                StopBits_i,
  output logic [4:0]          State_o,
  output logic [CNT_W-1:0]    BitCounter_o,
  output logic [DATA_MAX-1:0] Data_o,
  output logic                Done_o,
  output logic                ParityErr_o,
  output logic                FrameErr_o,
  output logic                TmrErr_o
);

  localparam logic [3:0]       MaxBits = 4'(DATA_MAX);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(DATA_MAX - 1);

  // Redundant copies and their voted views
  logic [4:0]       st0_q, st1_q, st2_q, st_v, st_d;
  logic [CNT_W-1:0] cnt0_q, cnt1_q, cnt2_q, cnt_v, cnt_d;
  cfg_t             cfg0_q, cfg1_q, cfg2_q, cfg_v, cfg_d;
  logic             mismatch;

  // Unvoted datapath
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic [DATA_MAX-1:0] data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                done_q, done_d;
  logic                perr_o_q, perr_o_d;
  logic                ferr_o_q, ferr_o_d;
  logic                tmr_err_q, tmr_err_d;

  if (TMR_EN) begin : g_tmr
    logic mm_st, mm_cnt, mm_cfg;

    tmr_vote #(.W(5)) u_vote_st (
      .a_i       (st0_q),
      .b_i       (st1_q),
      .c_i       (st2_q),
      .y_o       (st_v),
      .mismatch_o(mm_st)
    );

    tmr_vote #(.W(CNT_W)) u_vote_cnt (
      .a_i       (cnt0_q),
      .b_i       (cnt1_q),
      .c_i       (cnt2_q),
      .y_o       (cnt_v),
      .mismatch_o(mm_cnt)
    );

    tmr_vote #(.W(CFG_W)) u_vote_cfg (
      .a_i       (cfg0_q),
      .b_i       (cfg1_q),
      .c_i       (cfg2_q),
      .y_o       (cfg_v),
      .mismatch_o(mm_cfg)
    );

    assign mismatch = mm_st | mm_cnt | mm_cfg;
  end else begin : g_single
    assign st_v     = st0_q;
    assign cnt_v    = cnt0_q;
    assign cfg_v    = cfg0_q;
    assign mismatch = 1'b0;
  end

  logic             st_invalid;
  logic             par_en;
  logic [CNT_W-1:0] last_idx;
  logic             exp_par;

  assign st_invalid = !is_onehot5(st_v);
  assign par_en     = (cfg_v.parity == PAR_EVEN) || (cfg_v.parity == PAR_ODD);
  assign last_idx   = CNT_W'(cfg_v.data_bits) - CNT_W'(1);
  assign exp_par    = (^shift_q) ^ (cfg_v.parity == PAR_ODD);

  always_comb begin
    st_d      = st_v;
    cnt_d     = cnt_v;
    cfg_d     = cfg_v;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    perr_o_d  = perr_o_q;
    ferr_o_d  = ferr_o_q;
    tmr_err_d = TMR_EN ? (mismatch | st_invalid) : 1'b0;

    if (st_invalid) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
    end else begin
      unique case (st_v)
        ST_IDLE: begin
          if (Rx_Synch_i) begin
            st_d            = ST_START;
            cnt_d           = '0;
            cfg_d.data_bits = clamp_bits(DataBits_i, MaxBits);
            cfg_d.parity    = ParityMode_i;
            cfg_d.stop2     = StopBits_i;
            shift_d         = '0;
            perr_d          = 1'b0;
            ferr_d          = 1'b0;
          end
        end
        ST_START: begin
          if (AcqSig_i) begin
            st_d  = RxBit_i ? ST_IDLE : ST_DATA;
            cnt_d = '0;
          end
        end
        ST_DATA: begin
          if (AcqSig_i) begin
            if (cnt_v > CntMax) begin
              // Corrupted count: abandon data and close the frame.
              st_d  = ST_STOP;
              cnt_d = '0;
            end else begin
              for (int i = 0; i < DATA_MAX; i++) begin
                if (cnt_v == CNT_W'(i)) shift_d[i] = RxBit_i;
              end
              if (cnt_v >= last_idx) begin
                st_d  = par_en ? ST_PARITY : ST_STOP;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_v + CNT_W'(1);
              end
            end
          end
        end
        ST_PARITY: begin
          if (AcqSig_i) begin
            perr_d = (RxBit_i != exp_par);
            st_d   = ST_STOP;
            cnt_d  = '0;
          end
        end
        ST_STOP: begin
          if (AcqSig_i) begin
            if (!RxBit_i) ferr_d = 1'b1;
            if (cfg_v.stop2 && (cnt_v == '0)) begin
              cnt_d = CNT_W'(1);
            end else begin
              st_d     = ST_IDLE;
              cnt_d    = '0;
              done_d   = 1'b1;
              data_d   = shift_q;
              perr_o_d = perr_q;
              ferr_o_d = ferr_q | ~RxBit_i;
            end
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  // All copies are written from the single voted next-state, scrubbing upsets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st0_q     <= ST_IDLE;
      st1_q     <= ST_IDLE;
      st2_q     <= ST_IDLE;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      cfg0_q    <= '0;
      cfg1_q    <= '0;
      cfg2_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      perr_o_q  <= 1'b0;
      ferr_o_q  <= 1'b0;
      tmr_err_q <= 1'b0;
    end else begin
      st0_q     <= st_d;
      st1_q     <= st_d;
      st2_q     <= st_d;
      cnt0_q    <= cnt_d;
      cnt1_q    <= cnt_d;
      cnt2_q    <= cnt_d;
      cfg0_q    <= cfg_d;
      cfg1_q    <= cfg_d;
      cfg2_q    <= cfg_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      perr_o_q  <= perr_o_d;
      ferr_o_q  <= ferr_o_d;
      tmr_err_q <= tmr_err_d;
    end
  end

  assign State_o      = st_v;
  assign BitCounter_o = cnt_v;
  assign Data_o       = data_q;
  assign Done_o       = done_q;
  assign ParityErr_o  = perr_o_q;
  assign FrameErr_o   = ferr_o_q;
  assign TmrErr_o     = tmr_err_q;

endmodule

// File: tb/tb_fsm_rx_tmr_param.sv
// Directed bench for fsm_rx_tmr_param: frame formats, false start, TMR upsets
// and asynchronous reset, each with hand-computed expectations.
module tb_fsm_rx_tmr_param;

  localparam int unsigned DATA_MAX = 9;
  localparam int unsigned CNT_W    = 4;

  logic                clk;
  logic                rst;
  logic                Rx_Synch_i;
  logic                AcqSig_i;
  logic                RxBit_i;
  logic [3:0]          DataBits_i;
  logic [1:0]          ParityMode_i;
  logic                StopBits_i;
  logic [4:0]          State_o;
  logic [CNT_W-1:0]    BitCounter_o;
  logic [DATA_MAX-1:0] Data_o;
  logic                Done_o;
  logic                ParityErr_o;
  logic                FrameErr_o;
  logic                TmrErr_o;

  int n_tests;
  int n_fail;

  fsm_rx_tmr_param #(
    .DATA_MAX(DATA_MAX),
    .CNT_W   (CNT_W),
    .TMR_EN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Rx_Synch_i  (Rx_Synch_i),
    .AcqSig_i    (AcqSig_i),
    .RxBit_i     (RxBit_i),
    .DataBits_i  (DataBits_i),
    .ParityMode_i(ParityMode_i),
    .StopBits_i  (StopBits_i),
    .State_o     (State_o),
    .BitCounter_o(BitCounter_o),
    .Data_o      (Data_o),
    .Done_o      (Done_o),
    .ParityErr_o (ParityErr_o),
    .FrameErr_o  (FrameErr_o),
    .TmrErr_o    (TmrErr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Both tasks start and end on a falling edge.
  task automatic start_frame();
    Rx_Synch_i = 1'b1;
    @(negedge clk);
    Rx_Synch_i = 1'b0;
  endtask

  task automatic acq(input logic b);
    AcqSig_i = 1'b1;
    RxBit_i  = b;
    @(negedge clk);
    AcqSig_i = 1'b0;
    RxBit_i  = 1'b1;
  endtask

  initial begin
    logic [8:0] v;
    logic       done_seen;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b0;
    Rx_Synch_i   = 1'b0;
    AcqSig_i     = 1'b0;
    RxBit_i      = 1'b1;
    DataBits_i   = 4'd8;
    ParityMode_i = 2'b00;
    StopBits_i   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(State_o), 32'h01);
    chk("rst_cnt", 32'(BitCounter_o), 32'h0);
    chk("rst_data", 32'(Data_o), 32'h0);
    chk("rst_flags", {28'd0, Done_o, ParityErr_o, FrameErr_o, TmrErr_o}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // 8N1, 0xA5
    start_frame();
    chk("t1_start", 32'(State_o), 32'h02);
    acq(1'b0);
    chk("t1_data", 32'(State_o), 32'h04);
    v = 9'h0A5;
    for (int i = 0; i < 8; i++) acq(v[i]);
    chk("t1_stop", 32'(State_o), 32'h10);
    chk("t1_nodone", 32'(Done_o), 32'h0);
    acq(1'b1);
    chk("t1_done", 32'(Done_o), 32'h1);
    chk("t1_data_o", 32'(Data_o), 32'h0A5);
    chk("t1_errs", {30'd0, ParityErr_o, FrameErr_o}, 32'h0);
    chk("t1_idle", 32'(State_o), 32'h01);
    @(negedge clk);
    chk("t1_done_pulse", 32'(Done_o), 32'h0);

    // 7E2, 0x3C, wrong parity, second stop bit low
    DataBits_i   = 4'd7;
    ParityMode_i = 2'b01;
    StopBits_i   = 1'b1;
    start_frame();
    acq(1'b0);
    v = 9'h03C;
    for (int i = 0; i < 7; i++) acq(v[i]);
    chk("t2_parity_st", 32'(State_o), 32'h08);
    acq(1'b1);
    acq(1'b1);
    chk("t2_stop2_st", 32'(State_o), 32'h10);
    chk("t2_stop2_cnt", 32'(BitCounter_o), 32'h1);
    chk("t2_nodone10", 32'(Done_o), 32'h0);
    acq(1'b0);
    chk("t2_done11", 32'(Done_o), 32'h1);
    chk("t2_data_o", 32'(Data_o), 32'h03C);
    chk("t2_perr", 32'(ParityErr_o), 32'h1);
    chk("t2_ferr", 32'(FrameErr_o), 32'h1);

    // False start
    DataBits_i   = 4'd8;
    ParityMode_i = 2'b00;
    StopBits_i   = 1'b0;
    @(negedge clk);
    start_frame();
    acq(1'b1);
    chk("t3_idle", 32'(State_o), 32'h01);
    chk("t3_cnt", 32'(BitCounter_o), 32'h0);
    chk("t3_nodone", 32'(Done_o), 32'h0);

    // Single-copy upset mid-DATA, frame must still complete
    start_frame();
    acq(1'b0);
    v = 9'h05A;
    for (int i = 0; i < 3; i++) acq(v[i]);
    force dut.st1_q = 5'b10000;
    @(negedge clk);
    chk("t4_tmr_err", 32'(TmrErr_o), 32'h1);
    chk("t4_voted_st", 32'(State_o), 32'h04);
    release dut.st1_q;
    @(negedge clk);
    for (int i = 3; i < 8; i++) acq(v[i]);
    acq(1'b1);
    chk("t4_done", 32'(Done_o), 32'h1);
    chk("t4_data_o", 32'(Data_o), 32'h05A);
    chk("t4_errs", {30'd0, ParityErr_o, FrameErr_o}, 32'h0);
    // Non-one-hot state in all copies
    @(negedge clk);
    force dut.st0_q = 5'b00110;
    force dut.st1_q = 5'b00110;
    force dut.st2_q = 5'b00110;
    @(negedge clk);
    chk("t4_bad_tmr", 32'(TmrErr_o), 32'h1);
    release dut.st0_q;
    release dut.st1_q;
    release dut.st2_q;
    repeat (2) @(negedge clk);
    chk("t4_bad_idle", 32'(State_o), 32'h01);
    chk("t4_bad_clear", 32'(TmrErr_o), 32'h0);

    // 9O1, 0x1FF with correct odd parity 0; width change mid-frame ignored
    DataBits_i   = 4'd9;
    ParityMode_i = 2'b10;
    StopBits_i   = 1'b0;
    start_frame();
    acq(1'b0);
    for (int i = 0; i < 5; i++) acq(1'b1);
    DataBits_i = 4'd5;
    chk("t5_still_data", 32'(State_o), 32'h04);
    chk("t5_cnt5", 32'(BitCounter_o), 32'h5);
    for (int i = 5; i < 9; i++) acq(1'b1);
    chk("t5_parity_st", 32'(State_o), 32'h08);
    acq(1'b0);
    acq(1'b1);
    chk("t5_done", 32'(Done_o), 32'h1);
    chk("t5_data_o", 32'(Data_o), 32'h1FF);
    chk("t5_errs", {30'd0, ParityErr_o, FrameErr_o}, 32'h0);

    // Asynchronous reset mid-DATA
    DataBits_i   = 4'd8;
    ParityMode_i = 2'b00;
    start_frame();
    acq(1'b0);
    acq(1'b1);
    acq(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_state", 32'(State_o), 32'h01);
    chk("t6_cnt", 32'(BitCounter_o), 32'h0);
    chk("t6_data", 32'(Data_o), 32'h0);
    chk("t6_flags", {28'd0, Done_o, ParityErr_o, FrameErr_o, TmrErr_o}, 32'h0);
    @(negedge clk);
    rst       = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      acq(1'b1);
      if (Done_o) done_seen = 1'b1;
    end
    chk("t6_no_done", 32'(done_seen), 32'h0);
    chk("t6_idle", 32'(State_o), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
